// File: rtl/acc_pkg.sv
// Shared constants for the accumulator sequencer: datapath width,
// saturation bound, opcode/source encodings and FSM state encoding.
package acc_pkg;

  localparam int WIDTH   = 11;
  localparam int SAT_MAX = 999;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_NEG = 3'd3;
  localparam logic [2:0] OP_SAV = 3'd4;
  localparam logic [2:0] OP_SWP = 3'd5;
  localparam logic [2:0] OP_MOV = 3'd6;

  localparam logic [1:0] SRC_IMM  = 2'd0;
  localparam logic [1:0] SRC_PORT = 2'd1;
  localparam logic [1:0] SRC_ACC  = 2'd2;
  localparam logic [1:0] SRC_NIL  = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

endpackage

// File: rtl/acc_sequencer_sat_addsub.sv
// Combinational saturating add/subtract: the result is formed one bit wider
// than the operands so it cannot wrap, then clamped to +/-SAT_MAX.
module sat_addsub
  import acc_pkg::*;
(
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  output logic signed [WIDTH-1:0] y
);

  localparam logic signed [WIDTH:0] SAT_HI = (WIDTH+1)'(SAT_MAX);
  localparam logic signed [WIDTH:0] SAT_LO = -SAT_HI;

  function automatic logic signed [WIDTH-1:0] clamp_sat(input logic signed [WIDTH:0] v);
    if (v > SAT_HI)
      return SAT_HI[WIDTH-1:0];
    else if (v < SAT_LO)
      return SAT_LO[WIDTH-1:0];
    else
      return v[WIDTH-1:0];
  endfunction

  logic signed [WIDTH:0] ax;
  logic signed [WIDTH:0] bx;
  logic signed [WIDTH:0] sum;

  // Sign-extend, add or subtract at full precision, then saturate
  always_comb begin
    ax  = {a[WIDTH-1], a};
    bx  = {b[WIDTH-1], b};
    sum = sub ? (ax - bx) : (ax + bx);
    y   = clamp_sat(sum);
  end

endmodule

// File: rtl/acc_sequencer.sv
// Accumulator sequencer: accepts one instruction at a time, optionally waits
// for an operand on the input port, then updates ACC/BAK in a single execute
// cycle and pulses done. Flags are decoded straight from ACC.
module acc_sequencer
  import acc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [2:0]              op_code,
  input  logic [1:0]              op_src,
  input  logic signed [WIDTH-1:0] op_imm,
  input  logic                    port_valid,
  output logic                    port_ready,
  input  logic signed [WIDTH-1:0] port_data,
  output logic                    done,
  output logic signed [WIDTH-1:0] acc_out,
  output logic signed [WIDTH-1:0] bak_out,
  output logic                    flag_z,
  output logic                    flag_n,
  output logic                    flag_p
);

  logic [1:0]              state;
  logic [2:0]              code_p0;
  logic [1:0]              src_p0;
  logic signed [WIDTH-1:0] opnd_p0;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] bak;

  logic                    accept;
  logic                    take;
  logic                    needs_port;
  logic signed [WIDTH-1:0] opnd_clamped;
  logic signed [WIDTH-1:0] opnd_val;
  logic signed [WIDTH-1:0] alu_a;
  logic signed [WIDTH-1:0] alu_b;
  logic                    alu_sub;
  logic signed [WIDTH-1:0] alu_y;

  // Ready outputs are masked during reset so nothing is consumed that cycle
  assign op_ready   = (state == ST_IDLE) && !rst;
  assign port_ready = (state == ST_FETCH) && !rst;
  assign accept     = op_valid && op_ready;
  assign take       = port_valid && port_ready;
  assign needs_port = ((op_code == OP_ADD) || (op_code == OP_SUB) || (op_code == OP_MOV))
                      && (op_src == SRC_PORT);

  // Instruction sequencing: IDLE -> (FETCH) -> EXEC -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state <= needs_port ? ST_FETCH : ST_EXEC;
        ST_FETCH: if (take) state <= ST_EXEC;
        ST_EXEC:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p0: latched instruction and raw operand (immediate or port word)
  always_ff @(posedge clk) begin
    if (accept) begin
      code_p0 <= op_code;
      src_p0  <= op_src;
      opnd_p0 <= op_imm;
    end else if (take) begin
      opnd_p0 <= port_data;
    end
  end

  // The operand clamp is the saturating adder with a zero addend
  sat_addsub u_opnd_clamp (
    .a   (opnd_p0),
    .b   ('0),
    .sub (1'b0),
    .y   (opnd_clamped)
  );

  // Operand select and ALU input steering; NEG is computed as 0 - ACC
  always_comb begin
    opnd_val = '0;
    case (src_p0)
      SRC_IMM, SRC_PORT: opnd_val = opnd_clamped;
      SRC_ACC:           opnd_val = acc;
      default:           opnd_val = '0;
    endcase
    alu_a   = (code_p0 == OP_NEG) ? '0 : acc;
    alu_b   = (code_p0 == OP_NEG) ? acc : opnd_val;
    alu_sub = (code_p0 == OP_SUB) || (code_p0 == OP_NEG);
  end

  sat_addsub u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sub (alu_sub),
    .y   (alu_y)
  );

  // ---- stage p1: register write-back and retire pulse at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      bak  <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == ST_EXEC);
      if (state == ST_EXEC) begin
        case (code_p0)
          OP_ADD, OP_SUB, OP_NEG: acc <= alu_y;
          OP_SAV: bak <= acc;
          OP_SWP: begin
            acc <= bak;
            bak <= acc;
          end
          OP_MOV:  acc <= opnd_val;
          default: ;
        endcase
      end
    end
  end

  assign acc_out = acc;
  assign bak_out = bak;
  assign flag_z  = (acc == '0);
  assign flag_n  = acc[WIDTH-1];
  assign flag_p  = !acc[WIDTH-1] && (acc != '0);

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: directed scenarios plus randomized instruction
// streams, checked against an integer reference model of ACC/BAK.
module tb_acc_sequencer;
  import acc_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    op_valid;
  logic                    op_ready;
  logic [2:0]              op_code;
  logic [1:0]              op_src;
  logic signed [WIDTH-1:0] op_imm;
  logic                    port_valid;
  logic                    port_ready;
  logic signed [WIDTH-1:0] port_data;
  logic                    done;
  logic signed [WIDTH-1:0] acc_out;
  logic signed [WIDTH-1:0] bak_out;
  logic                    flag_z;
  logic                    flag_n;
  logic                    flag_p;

  int vectors     = 0;
  int miscompares = 0;
  int m_acc       = 0;
  int m_bak       = 0;

  acc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_src     (op_src),
    .op_imm     (op_imm),
    .port_valid (port_valid),
    .port_ready (port_ready),
    .port_data  (port_data),
    .done       (done),
    .acc_out    (acc_out),
    .bak_out    (bak_out),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_p     (flag_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampv(input int v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < -SAT_MAX) return -SAT_MAX;
    return v;
  endfunction

  // Value the DUT actually sees for an int driven onto an 11-bit port
  function automatic int as_word(input int v);
    logic signed [WIDTH-1:0] w;
    w = WIDTH'(v);
    return int'(w);
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, "_acc"}, int'(acc_out), m_acc);
    chk({tag, "_bak"}, int'(bak_out), m_bak);
    chk({tag, "_z"}, int'(flag_z), int'(m_acc == 0));
    chk({tag, "_n"}, int'(flag_n), int'(m_acc < 0));
    chk({tag, "_p"}, int'(flag_p), int'(m_acc > 0));
  endtask

  // Issue one instruction starting at a negedge; returns at the negedge where
  // done must be high, so the next call exercises back-to-back acceptance.
  task automatic do_op(input logic [2:0] c, input logic [1:0] s, input int imm,
                       input int waits, input int pdata, input string tag);
    bit use_port;
    int opnd;
    use_port = ((c == OP_ADD) || (c == OP_SUB) || (c == OP_MOV)) && (s == SRC_PORT);
    op_valid = 1'b1;
    op_code  = c;
    op_src   = s;
    op_imm   = WIDTH'(imm);
    #1;
    chk({tag, "_op_ready"}, int'(op_ready), 1);
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 3'($urandom);
    op_src   = 2'($urandom);
    op_imm   = WIDTH'($urandom);
    case (s)
      SRC_IMM:  opnd = clampv(as_word(imm));
      SRC_PORT: opnd = clampv(as_word(pdata));
      SRC_ACC:  opnd = m_acc;
      default:  opnd = 0;
    endcase
    if (use_port) begin
      for (int i = 0; i < waits; i++) begin
        port_data = WIDTH'($urandom);
        #1;
        chk({tag, "_wait_pready"}, int'(port_ready), 1);
        chk({tag, "_wait_oready"}, int'(op_ready), 0);
        chk({tag, "_wait_done"}, int'(done), 0);
        @(negedge clk);
      end
      #1;
      chk({tag, "_pready"}, int'(port_ready), 1);
      port_valid = 1'b1;
      port_data  = WIDTH'(pdata);
      @(negedge clk);
      port_valid = 1'b0;
      port_data  = WIDTH'($urandom);
      #1;
      chk({tag, "_pready_drop"}, int'(port_ready), 0);
    end else begin
      #1;
      chk({tag, "_no_fetch"}, int'(port_ready), 0);
    end
    chk({tag, "_done_early"}, int'(done), 0);
    chk({tag, "_busy"}, int'(op_ready), 0);
    case (c)
      OP_ADD: m_acc = clampv(m_acc + opnd);
      OP_SUB: m_acc = clampv(m_acc - opnd);
      OP_NEG: m_acc = -m_acc;
      OP_SAV: m_bak = m_acc;
      OP_SWP: begin
        int t;
        t = m_acc;
        m_acc = m_bak;
        m_bak = t;
      end
      OP_MOV: m_acc = opnd;
      default: ;
    endcase
    @(negedge clk);
    chk({tag, "_done"}, int'(done), 1);
    chk_regs(tag);
  endtask

  initial begin
    rst        = 1'b1;
    op_valid   = 1'b0;
    op_code    = '0;
    op_src     = '0;
    op_imm     = '0;
    port_valid = 1'b0;
    port_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_op_ready", int'(op_ready), 1);
    chk("rst_port_ready", int'(port_ready), 0);
    chk("rst_done", int'(done), 0);
    chk_regs("rst");

    // Saturating add
    do_op(OP_MOV, SRC_IMM, 500, 0, 0, "t1_mov");
    do_op(OP_ADD, SRC_IMM, 500, 0, 0, "t1_add");
    // Negative saturation and immediate clamp (largest 11-bit immediate)
    do_op(OP_MOV, SRC_IMM, -500, 0, 0, "t2_mov");
    do_op(OP_SUB, SRC_IMM, 999, 0, 0, "t2_sub");
    do_op(OP_MOV, SRC_IMM, 1023, 0, 0, "t2_clamp");
    do_op(OP_MOV, SRC_IMM, -1024, 0, 0, "t2_clampn");
    // SAV / SWP / NEG
    do_op(OP_MOV, SRC_IMM, 7, 0, 0, "t3_mov7");
    do_op(OP_SAV, SRC_PORT, 0, 0, 0, "t3_sav");
    do_op(OP_MOV, SRC_IMM, -3, 0, 0, "t3_movm3");
    do_op(OP_SWP, SRC_PORT, 0, 0, 0, "t3_swp");
    do_op(OP_NEG, SRC_PORT, 0, 0, 0, "t3_neg");
    // Port operand with a stalled producer
    do_op(OP_ADD, SRC_PORT, 0, 5, 12, "t4_addport");
    // ACC as source, then NOP
    do_op(OP_MOV, SRC_IMM, 600, 0, 0, "t5_mov");
    do_op(OP_ADD, SRC_ACC, 0, 0, 0, "t5_dbl");
    do_op(OP_SUB, SRC_ACC, 0, 0, 0, "t5_zero");
    do_op(OP_MOV, SRC_IMM, 42, 0, 0, "t5_mov42");
    do_op(OP_NOP, SRC_PORT, 0, 0, 0, "t5_nop");

    // Reset while waiting on the port with data offered
    do_op(OP_SAV, SRC_IMM, 0, 0, 0, "t6_sav");
    op_valid = 1'b1;
    op_code  = OP_ADD;
    op_src   = SRC_PORT;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    chk("t6_in_fetch", int'(port_ready), 1);
    port_valid = 1'b1;
    port_data  = WIDTH'(77);
    rst        = 1'b1;
    #1;
    chk("t6_pready_rst", int'(port_ready), 0);
    @(negedge clk);
    rst        = 1'b0;
    port_valid = 1'b0;
    m_acc      = 0;
    m_bak      = 0;
    #1;
    chk("t6_no_done", int'(done), 0);
    chk("t6_idle", int'(op_ready), 1);
    chk_regs("t6");
    do_op(OP_ADD, SRC_PORT, 0, 0, 5, "t6_after");

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [2:0] c;
      logic [1:0] s;
      c = 3'($urandom_range(0, 6));
      s = 2'($urandom_range(0, 3));
      do_op(c, s, int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 2047)) - 1024, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
